mdu: RTL and testbench
======================

# mdu

Parametrised multiply/divide unit for the pipelined CPU's execute stage. It sits alongside the ALU and receives the 4-bit MDU opcode produced by the control unit. It performs signed and unsigned multiply and divide with configurable multi-cycle latencies, and holds the architectural HI/LO registers. It exposes busy and stall-request signals to the hazard unit, and accepts a flush that cancels an in-flight operation.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu; legal range 1..255.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid in E stage this cycle.
- `mdu_op`  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 0 none.
- `rs_data`  in  WIDTH  forwarded rs value (dividend / multiplicand / mthi/mtlo source).
- `rt_data`  in  WIDTH  forwarded rt value (divisor / multiplier).
- `flush`  in  1  cancel the in-flight op; blocks a new op in the same cycle.
- `busy`  out  1  registered; high while a mult/div is in flight.
- `stall_req`  out  1  combinational; `busy | (start & mdu_op in 1..8)`.
- `hi`  out  WIDTH  registered HI.
- `lo`  out  WIDTH  registered LO.
- `rd_data`  out  WIDTH  combinational; `hi` for op 5, `lo` for op 6, else 0.

## Operation
- States: IDLE and RUN. A down-counter `cnt` (8 bits) and latched result registers `res_hi`/`res_lo` back the RUN state.
- IDLE, with `start`, op 1..4 and no `flush`:
  - compute the result from `rs_data`/`rt_data` into `res_hi`/`res_lo`;
  - load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN with `busy`=1.
- RUN: decrement `cnt` each cycle. When `cnt`==1 at an edge, copy `res_hi`/`res_lo` into `hi`/`lo`, clear `busy` and return to IDLE.
- mult: `{hi,lo}` = signed product (2·WIDTH bits). multu: unsigned product.
- div: `lo` = quotient truncated toward zero; `hi` = remainder, with the sign of the dividend. divu: unsigned quotient and remainder.
- Divide by zero (div or divu): `lo` = all ones, `hi` = dividend.
- Signed overflow (MIN_INT / -1): `lo` = MIN_INT, `hi` = 0.
- mthi/mtlo (op 7/8) in IDLE with `start`, no `flush`: write `rs_data` to `hi`/`lo` at that edge. `busy` is not raised.
- mfhi/mflo: pure read through `rd_data`; no state change.
- Any `start` while `busy`=1 is ignored. The hazard unit must hold the instruction, using `stall_req`.
- `flush` while in RUN: return to IDLE at that edge, `busy`=0, and leave `hi`/`lo` unchanged (the result is discarded).
- `flush` together with `start` in IDLE: the op is dropped; nothing is written.
- `mdu_op` values 9..15 are treated as 0.

## Timing
- Reset (asynchronous, while `rst_n`=0): `hi`=0, `lo`=0, `busy`=0, state IDLE, `cnt`=0, `res_hi`/`res_lo`=0. `stall_req` and `rd_data` follow their combinational definitions.
- Mult/div accepted at edge k:
  - `busy` high from edge k to edge k+N, exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`);
  - `hi`/`lo` show the new result after edge k+N;
  - a new op can be accepted at edge k+N+1 at the earliest.
- mthi/mtlo: zero latency beyond the accepting edge. A following mfhi in the next cycle reads the new value.
- Reset asserted mid-operation: immediate return to reset values. No partial HI/LO update ever occurs.
- `flush` and completion on the same edge (`cnt`==1): flush wins and HI/LO stay unchanged.

## Test plan
- Reset: drive `rst_n`=0 mid-RUN -> `busy`=0, `hi`=`lo`=0 immediately.
- mult, rs=0xFFFFFFFE (-2), rt=3:
  - `busy` high for exactly 5 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- multu, same operands -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div:
  - rs=-7, rt=2 -> after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF;
  - rs=0x80000000, rt=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0;
  - rt=0 -> `lo`=0xFFFFFFFF, `hi`=rs.
- Flush: start divu, then pulse `flush` on cycle 4 -> `busy` falls at that edge and `hi`/`lo` keep their prior values. Repeat with `flush` on the completion cycle -> same result.
- mthi 0x1234 then mflo/mfhi:
  - `rd_data` returns 0x1234 the next cycle;
  - `start` with mult while `busy` -> ignored, and `stall_req`=1 throughout RUN.

Source files
------------

// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO registers.
// Results are computed when an operation is accepted and held in res_hi/res_lo.
// They are committed to HI/LO only after the configured busy latency has elapsed.
// A flush discards the pending result without touching HI/LO.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [7:0]       MULT_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0]       DIV_CNT  = 8'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;

  // Arithmetic datapath signals (combinational, from the forwarded operands)
  logic [2*WIDTH-1:0] a_sext, b_sext;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               rs_neg, rt_neg, rt_zero, div_ovf;
  logic [WIDTH-1:0]   rs_mag, rt_mag, den_s, den_u;
  logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [WIDTH-1:0]   div_hi, div_lo, divu_hi, divu_lo;
  logic               op_valid;

  // Compute signed/unsigned products and quotients/remainders from the operands
  always_comb begin
    a_sext  = {{WIDTH{rs_data[WIDTH-1]}}, rs_data};
    b_sext  = {{WIDTH{rt_data[WIDTH-1]}}, rt_data};
    prod_s  = a_sext * b_sext;
    prod_u  = {ZERO, rs_data} * {ZERO, rt_data};

    rs_neg  = rs_data[WIDTH-1];
    rt_neg  = rt_data[WIDTH-1];
    rt_zero = (rt_data == ZERO);
    div_ovf = (rs_data == MIN_INT) && (rt_data == ONES);

    // Signed divide is done on magnitudes; the divisor is forced to one when
    // zero so the dividers never see a zero denominator.
    rs_mag  = rs_neg ? (~rs_data + ONE) : rs_data;
    rt_mag  = rt_neg ? (~rt_data + ONE) : rt_data;
    den_s   = rt_zero ? ONE : rt_mag;
    den_u   = rt_zero ? ONE : rt_data;

    q_mag   = rs_mag / den_s;
    r_mag   = rs_mag % den_s;
    q_s     = (rs_neg ^ rt_neg) ? (~q_mag + ONE) : q_mag;
    r_s     = rs_neg ? (~r_mag + ONE) : r_mag;
    q_u     = rs_data / den_u;
    r_u     = rs_data % den_u;

    if (rt_zero) begin
      div_hi = rs_data;
      div_lo = ONES;
    end else if (div_ovf) begin
      div_hi = ZERO;
      div_lo = MIN_INT;
    end else begin
      div_hi = r_s;
      div_lo = q_s;
    end

    if (rt_zero) begin
      divu_hi = rs_data;
      divu_lo = ONES;
    end else begin
      divu_hi = r_u;
      divu_lo = q_u;
    end
  end

  // Next-state logic: accept ops in IDLE, count down in RUN, commit or flush
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          case (mdu_op)
            4'd1: begin
              res_hi_d = prod_s[2*WIDTH-1:WIDTH];
              res_lo_d = prod_s[WIDTH-1:0];
              cnt_d    = MULT_CNT;
              state_d  = ST_RUN;
              busy_d   = 1'b1;
            end
            4'd2: begin
              res_hi_d = prod_u[2*WIDTH-1:WIDTH];
              res_lo_d = prod_u[WIDTH-1:0];
              cnt_d    = MULT_CNT;
              state_d  = ST_RUN;
              busy_d   = 1'b1;
            end
            4'd3: begin
              res_hi_d = div_hi;
              res_lo_d = div_lo;
              cnt_d    = DIV_CNT;
              state_d  = ST_RUN;
              busy_d   = 1'b1;
            end
            4'd4: begin
              res_hi_d = divu_hi;
              res_lo_d = divu_lo;
              cnt_d    = DIV_CNT;
              state_d  = ST_RUN;
              busy_d   = 1'b1;
            end
            4'd7: hi_d = rs_data;
            4'd8: lo_d = rs_data;
            default: begin
              // mfhi/mflo, none and undefined opcodes leave state untouched
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          // Pending result is discarded; HI/LO keep their old values
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else if (cnt_q == 8'd1) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      res_hi_q <= ZERO;
      res_lo_q <= ZERO;
      hi_q     <= ZERO;
      lo_q     <= ZERO;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  // Hazard request and mfhi/mflo read port
  always_comb begin
    op_valid  = (mdu_op >= 4'd1) && (mdu_op <= 4'd8);
    stall_req = busy_q | (start & op_valid);
    case (mdu_op)
      4'd5:    rd_data = hi_q;
      4'd6:    rd_data = lo_q;
      default: rd_data = ZERO;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu with a scoreboard queue of expected {hi,lo}.
module tb_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk, rst_n, start, flush;
  logic [3:0]   mdu_op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, stall_req;
  logic [W-1:0] hi, lo, rd_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [W-1:0] m_hi, m_lo;

  mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the architectural result {hi,lo}
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb, q, r;
    longint p;
    logic [63:0] res;
    sa = a;
    sb = b;
    res = 64'd0;
    case (op)
      4'd1: begin p = longint'(sa) * longint'(sb); res = p; end
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'd0, 32'h80000000};
        else begin q = sa / sb; r = sa % sb; res = {r, q}; end
      end
      4'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Issue a mult/div, count busy cycles, then pop the scoreboard and compare
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input bit hold);
    int cyc;
    logic [63:0] exp;
    sb_q.push_back(model(op, a, b));
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 300) begin
      if (hold) begin
        start = 1'b1; mdu_op = 4'd1; rs_data = 32'h00000007; rt_data = 32'h00000009;
        #1;
        chk({tag, "_stall"}, {63'd0, stall_req}, 64'd1);
      end
      cyc++;
      tick();
    end
    start = 1'b0; mdu_op = 4'd0;
    chk({tag, "_cycles"}, 64'(cyc), 64'(n));
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      chk({tag, "_hilo"}, {hi, lo}, exp);
    end else begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end
  endtask

  // Issue an op and flush it on the given cycle; HI/LO must be unchanged
  task automatic flush_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int at);
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    repeat (at - 1) tick();
    chk({tag, "_busy_pre"}, {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk({tag, "_busy_post"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    tick();
    chk({tag, "_hilo_late"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mdu_op = 4'd0;
    rs_data = 32'd0; rt_data = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    #9 rst_n = 1'b1;
    tick();

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, MC, 1'b0);
    chk("mult_spec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, MC, 1'b0);
    chk("multu_spec", {hi, lo}, 64'h00000002_FFFFFFFA);
    run_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, DC, 1'b0);
    chk("div_spec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, DC, 1'b0);
    run_op("div_zero", 4'd3, 32'h00000123, 32'd0, DC, 1'b0);
    run_op("divu", 4'd4, 32'd100, 32'd7, DC, 1'b0);
    run_op("divu_zero", 4'd4, 32'hDEADBEEF, 32'd0, DC, 1'b0);
    run_op("div_mix", 4'd3, 32'd17, 32'hFFFFFFFB, DC, 1'b0);
    run_op("mult_big", 4'd1, 32'h80000000, 32'h80000000, MC, 1'b0);

    flush_op("flush4", 4'd4, 32'd1000, 32'd3, 4);
    flush_op("flush_done", 4'd4, 32'd1000, 32'd3, DC);

    // flush together with start in IDLE drops the op
    start = 1'b1; flush = 1'b1; mdu_op = 4'd7; rs_data = 32'h55555555;
    tick();
    start = 1'b1; mdu_op = 4'd1; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0; mdu_op = 4'd0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    chk("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

    // mthi then mfhi/mflo
    start = 1'b1; mdu_op = 4'd7; rs_data = 32'h00001234;
    tick();
    m_hi = 32'h00001234;
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    mdu_op = 4'd5; #1;
    chk("mfhi", {32'd0, rd_data}, {32'd0, m_hi});
    mdu_op = 4'd6; #1;
    chk("mflo", {32'd0, rd_data}, {32'd0, m_lo});
    mdu_op = 4'd8; rs_data = 32'hCAFEF00D;
    tick();
    m_lo = 32'hCAFEF00D;
    mdu_op = 4'd6; #1;
    chk("mtlo_mflo", {32'd0, rd_data}, {32'd0, m_lo});
    mdu_op = 4'd12; #1;
    chk("op12_stall", {63'd0, stall_req}, 64'd0);
    chk("op12_rd", {32'd0, rd_data}, 64'd0);
    start = 1'b0; mdu_op = 4'd0;
    tick();

    // start while busy is ignored; stall_req held high throughout
    run_op("mult_hold", 4'd1, 32'd12345, 32'hFFFFFF00, MC, 1'b1);
    tick();
    chk("hold_idle", {63'd0, busy}, 64'd0);

    // asynchronous reset in the middle of a divide
    start = 1'b1; mdu_op = 4'd3; rs_data = 32'd77; rt_data = 32'd5;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    #1 rst_n = 1'b1;
    tick();
    run_op("post_rst", 4'd2, 32'd6, 32'd7, MC, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
